// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the shared-RAM arbiter: packed per-requester requests
// plus the shared read-response channel.
interface ram_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 9
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]      req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [WIDTH-1:0]              rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares a 1R1W synchronous RAM among NUM_REQ requesters with independent
// round-robin read and write arbitration and write-to-read collision forwarding.
module ram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  ram_port_arbiter_if.slave     bus,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [WIDTH-1:0]      ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [WIDTH-1:0]      ram_rd_data
);

  // Returns {found, index}: first set candidate scanning upward from ptr, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                             input logic [IDX_W-1:0]   ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

  logic [IDX_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [IDX_W-1:0] rd_idx_reg;
  logic             rd_pend_reg;
  logic             fwd_hit_reg;
  logic [WIDTH-1:0] fwd_data_reg;

  logic [NUM_REQ-1:0] rd_cand, wr_cand;
  logic [IDX_W:0]     rd_pick, wr_pick;
  logic [IDX_W-1:0]   rd_win, wr_win;
  logic               rd_grant, wr_grant;
  logic               fwd_hit_next;

  assign wr_cand = bus.req_valid & bus.req_we;
  assign rd_cand = bus.req_valid & ~bus.req_we;

  assign rd_pick = rr_pick(rd_cand, rd_ptr_reg);
  assign wr_pick = rr_pick(wr_cand, wr_ptr_reg);
  assign rd_win  = rd_pick[IDX_W-1:0];
  assign wr_win  = wr_pick[IDX_W-1:0];

  // Grants depend only on req_valid/req_we, never on req_ready.
  assign rd_grant = enable && rst_n && rd_pick[IDX_W];
  assign wr_grant = enable && rst_n && wr_pick[IDX_W];

  assign ram_rd_en   = rd_grant;
  assign ram_rd_addr = bus.req_addr[rd_win*ADDR_WIDTH +: ADDR_WIDTH];
  assign ram_wr_en   = wr_grant;
  assign ram_wr_addr = bus.req_addr[wr_win*ADDR_WIDTH +: ADDR_WIDTH];
  assign ram_wr_data = bus.req_wdata[wr_win*WIDTH +: WIDTH];

  assign fwd_hit_next = rd_grant && wr_grant && (ram_rd_addr == ram_wr_addr);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign bus.req_ready[gi] = (rd_grant && (rd_win == IDX_W'(gi))) ||
                               (wr_grant && (wr_win == IDX_W'(gi)));
    assign bus.rsp_valid[gi] = rd_pend_reg && (rd_idx_reg == IDX_W'(gi));
  end

  // The RAM returns pre-write data on a same-address collision, so substitute.
  assign bus.rsp_rdata = !rd_pend_reg ? '0 :
                         (fwd_hit_reg ? fwd_data_reg : ram_rd_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      rd_idx_reg   <= '0;
      rd_pend_reg  <= 1'b0;
      fwd_hit_reg  <= 1'b0;
      fwd_data_reg <= '0;
    end else begin
      if (rd_grant) rd_ptr_reg <= ptr_after(rd_win);
      if (wr_grant) wr_ptr_reg <= ptr_after(wr_win);
      rd_pend_reg <= rd_grant;
      if (rd_grant) rd_idx_reg <= rd_win;
      fwd_hit_reg <= fwd_hit_next;
      if (fwd_hit_next) fwd_data_reg <= ram_wr_data;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a read-first behavioural 1R1W RAM.
module tb_ram_port_arbiter;
  localparam int NR = 4;
  localparam int W  = 32;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic          ram_wr_en, ram_rd_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [W-1:0]  ram_wr_data, ram_rd_data;
  logic [W-1:0]  mem [0:511];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  ram_port_arbiter #(.NUM_REQ(NR), .WIDTH(W), .DEPTH(512)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .bus         (bus),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  // Read-first RAM; preload values are loaded while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[0]  <= 32'h10;
      mem[1]  <= 32'h11;
      mem[2]  <= 32'h12;
      mem[3]  <= 32'h13;
      mem[9]  <= 32'h55;
      mem[12] <= 32'h1;
    end else begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr,
                         input logic [W-1:0] data);
    bus.req_valid[i]          = 1'b1;
    bus.req_we[i]             = we;
    bus.req_addr[i*AW +: AW]  = addr;
    bus.req_wdata[i*W +: W]   = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    clear_reqs();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(i), '0);

    // Reset holds off all grants even with every requester valid
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_wr_en", 64'(ram_wr_en), 64'h0);
    chk("rst_rd_en", 64'(ram_rd_en), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
    tick();
    rst_n = 1'b1;

    // Round robin: all four read continuously, grants 0,1,2,3,0
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("rr_ready_%0d", c), 64'(bus.req_ready), 64'(1) << (c % 4));
      chk($sformatf("rr_rd_addr_%0d", c), 64'(ram_rd_addr), 64'(c % 4));
      if (c > 0) begin
        chk($sformatf("rr_rsp_valid_%0d", c), 64'(bus.rsp_valid), 64'(1) << ((c - 1) % 4));
        chk($sformatf("rr_rsp_rdata_%0d", c), 64'(bus.rsp_rdata), 64'h10 + 64'((c - 1) % 4));
      end
      tick();
    end
    clear_reqs();
    @(negedge clk);
    chk("rr_rsp_valid_last", 64'(bus.rsp_valid), 64'b0001);
    chk("rr_rsp_rdata_last", 64'(bus.rsp_rdata), 64'h10);
    chk("idle_ready", 64'(bus.req_ready), 64'h0);

    // Write then read back through a different requester
    tick();
    set_req(0, 1'b1, 9'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_ready", 64'(bus.req_ready), 64'b0001);
    chk("wr_en", 64'(ram_wr_en), 64'h1);
    chk("wr_addr", 64'(ram_wr_addr), 64'd5);
    chk("wr_data", 64'(ram_wr_data), 64'hDEADBEEF);
    tick();
    clear_reqs();
    set_req(2, 1'b0, 9'd5, '0);
    @(negedge clk);
    chk("rdback_ready", 64'(bus.req_ready), 64'b0100);
    chk("rdback_rd_en", 64'(ram_rd_en), 64'h1);
    tick();
    clear_reqs();
    @(negedge clk);
    chk("rdback_rsp_valid", 64'(bus.rsp_valid), 64'b0100);
    chk("rdback_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);

    // Concurrent read and write at different addresses
    tick();
    set_req(1, 1'b1, 9'd7, 32'hA5);
    set_req(3, 1'b0, 9'd9, '0);
    @(negedge clk);
    chk("conc_ready", 64'(bus.req_ready), 64'b1010);
    chk("conc_wr_addr", 64'(ram_wr_addr), 64'd7);
    chk("conc_rd_addr", 64'(ram_rd_addr), 64'd9);
    tick();
    clear_reqs();
    @(negedge clk);
    chk("conc_rsp_valid", 64'(bus.rsp_valid), 64'b1000);
    chk("conc_rsp_rdata", 64'(bus.rsp_rdata), 64'h55);

    // Same-cycle same-address collision returns the new data
    tick();
    set_req(0, 1'b0, 9'd12, '0);
    set_req(1, 1'b1, 9'd12, 32'h2);
    @(negedge clk);
    chk("coll_ready", 64'(bus.req_ready), 64'b0011);
    tick();
    clear_reqs();
    @(negedge clk);
    chk("coll_rsp_valid", 64'(bus.rsp_valid), 64'b0001);
    chk("coll_rsp_rdata", 64'(bus.rsp_rdata), 64'h2);

    // Plain re-read of the collided address, pointer past requester 0
    tick();
    set_req(0, 1'b0, 9'd12, '0);
    @(negedge clk);
    chk("single_ready", 64'(bus.req_ready), 64'b0001);
    tick();
    clear_reqs();
    @(negedge clk);
    chk("reread_rsp_rdata", 64'(bus.rsp_rdata), 64'h2);

    // enable drops after a grant: response still arrives, no new grants
    tick();
    set_req(2, 1'b0, 9'd9, '0);
    @(negedge clk);
    chk("en_ready", 64'(bus.req_ready), 64'b0100);
    tick();
    enable = 1'b0;
    set_req(0, 1'b0, 9'd0, '0);
    @(negedge clk);
    chk("en_rsp_valid", 64'(bus.rsp_valid), 64'b0100);
    chk("en_rsp_rdata", 64'(bus.rsp_rdata), 64'h55);
    chk("en_off_ready", 64'(bus.req_ready), 64'h0);
    chk("en_off_rd_en", 64'(ram_rd_en), 64'h0);
    tick();
    @(negedge clk);
    chk("en_off_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("en_off_ready2", 64'(bus.req_ready), 64'h0);
    tick();
    clear_reqs();
    enable = 1'b1;

    // Reset right after a read grant drops the response
    set_req(3, 1'b0, 9'd9, '0);
    @(negedge clk);
    chk("mrst_ready", 64'(bus.req_ready), 64'b1000);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("mrst_rd_en", 64'(ram_rd_en), 64'h0);
    tick();
    rst_n = 1'b1;
    clear_reqs();
    @(negedge clk);
    chk("mrst_rsp_valid_after", 64'(bus.rsp_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
